// File: rtl/data_sram_like_slave.sv
// data_sram_like_slave: sram-like data memory responder
// in-order responses after a fixed latency, bounded outstanding

module data_sram_like_slave #(
  parameter int MEM_AW      = 10,
  parameter int DATA_LAT    = 1,
  parameter int ADDR_OK_DLY = 0,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         DEPTH    = 2 ** MEM_AW;
  localparam logic [2:0] LAT_INIT = 3'(DATA_LAT - 1);
  localparam logic [2:0] DLY_MAX  = 3'(ADDR_OK_DLY);
  localparam logic [2:0] OS_MAX   = 3'(OUTSTANDING);

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    logic [2:0]  cnt;
  } ent_t;

  logic [31:0]       mem [DEPTH];

  ent_t              fifo_q [OUTSTANDING];
  ent_t              fifo_d [OUTSTANDING];
  logic [2:0]        count_q;
  logic [2:0]        count_d;
  logic [2:0]        wait_q;
  logic [2:0]        wait_d;

  logic [MEM_AW-1:0] widx;
  logic [31:0]       rd_word;
  logic [2:0]        push_idx;
  logic              pop;
  logic              room;
  logic              dly_met;
  logic              accept;
  logic              unused_bits;

  // size and the ignored address bits carry no function here
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign widx    = addr[MEM_AW+1:2];
  assign rd_word = mem[widx];

  // head response fires when its countdown has expired
  always_comb begin
    pop     = 1'b0;
    data_ok = 1'b0;
    rdata   = 32'h0;
    if (count_q != 3'd0 && fifo_q[0].cnt == 3'd0) begin
      pop     = 1'b1;
      data_ok = 1'b1;
      if (fifo_q[0].is_rd) begin
        rdata = fifo_q[0].data;
      end
    end
  end

  // a same-cycle pop frees the slot the new request takes
  always_comb begin
    room    = (count_q < OS_MAX) || pop;
    dly_met = (wait_q == DLY_MAX);
    addr_ok = room && dly_met;
    accept  = req && addr_ok;
  end

  // fifo next state: shift on pop, age all entries, append on accept
  always_comb begin
    fifo_d   = fifo_q;
    push_idx = count_q - {2'b0, pop};
    count_d  = count_q + {2'b0, accept} - {2'b0, pop};
    if (pop) begin
      for (int i = 0; i < OUTSTANDING - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      fifo_d[OUTSTANDING-1] = '0;
    end
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (fifo_d[i].cnt != 3'd0) begin
        fifo_d[i].cnt = fifo_d[i].cnt - 3'd1;
      end
    end
    if (accept) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (push_idx == 3'(i)) begin
          fifo_d[i].is_rd = !wr;
          fifo_d[i].data  = wr ? 32'h0 : rd_word;
          fifo_d[i].cnt   = LAT_INIT;
        end
      end
    end
  end

  // wait counter saturates at the required hold time
  always_comb begin
    wait_d = wait_q;
    if (accept) begin
      wait_d = 3'd0;
    end else if (req && wait_q != DLY_MAX) begin
      wait_d = wait_q + 3'd1;
    end
  end

  // response queue and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wait_q  <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wait_q  <= wait_d;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // byte-masked memory write on the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
